// File: rtl/locked_key_pkg.sv
// Shared types and helpers for the locked-netlist key loader.
package locked_key_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY, LOCKOUT} state_t;

    localparam int DEF_KEY_WIDTH = 4;
    localparam int DEF_MAX_FAILS = 3;

    // Even parity over a key zero-extended to 64 bits.
    function automatic logic even_parity(input logic [63:0] v);
        return ^v;
    endfunction
endpackage

// File: rtl/key_shift_reg.sv
// Key staging register: indexed bit write, synchronous clear, parallel read.
module key_shift_reg #(
    parameter int WIDTH = 4,
    parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] idx,
    input  logic             din,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        q      <= '0;
        else if (clr)   q      <= '0;
        else if (wr_en) q[idx] <= din;
    end
endmodule

// File: rtl/locked_key_loader.sv
// Serial key loader with even-parity check and failure lockout for a logic-locked core.
module locked_key_loader
    import locked_key_pkg::*;
#(
    parameter int KEY_WIDTH = DEF_KEY_WIDTH,
    parameter int MAX_FAILS = DEF_MAX_FAILS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_start,
    input  logic                 load_abort,
    input  logic                 ser_valid,
    input  logic                 ser_data,
    output logic                 ser_ready,
    output logic [KEY_WIDTH-1:0] key_out,
    output logic                 key_valid,
    output logic                 busy,
    output logic                 err,
    output logic                 locked_out
);
    localparam int CNT_W  = (KEY_WIDTH > 1) ? $clog2(KEY_WIDTH) : 1;
    localparam int FAIL_W = (MAX_FAILS > 0) ? $clog2(MAX_FAILS + 1) : 1;

    state_t               state, state_d;
    logic [CNT_W-1:0]     count;
    logic [FAIL_W-1:0]    fail_cnt;
    logic [FAIL_W-1:0]    fail_next;
    logic [KEY_WIDTH-1:0] shreg;
    logic                 transfer, par;
    logic                 do_start, do_write, do_accept, do_fail, to_lock;

    key_shift_reg #(.WIDTH(KEY_WIDTH), .IDX_W(CNT_W)) u_sr (
        .clk   (clk),
        .rst   (rst),
        .clr   (do_start),
        .wr_en (do_write),
        .idx   (count),
        .din   (ser_data),
        .q     (shreg)
    );

    assign ser_ready = (state == SHIFT) || (state == PARITY);
    assign transfer  = ser_valid && ser_ready;
    assign par       = even_parity(64'(shreg));
    assign fail_next = fail_cnt + FAIL_W'(1);
    assign to_lock   = (fail_next == FAIL_W'(MAX_FAILS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // Abort outranks a same-cycle transfer; a failure lands in LOCKOUT on the MAX_FAILS-th miss.
    always_comb begin
        state_d   = state;
        do_start  = 1'b0;
        do_write  = 1'b0;
        do_accept = 1'b0;
        do_fail   = 1'b0;
        case (state)
            IDLE: if (load_start) begin
                do_start = 1'b1;
                state_d  = SHIFT;
            end
            SHIFT: begin
                if (load_abort) do_fail = 1'b1;
                else if (transfer) begin
                    do_write = 1'b1;
                    if (count == CNT_W'(KEY_WIDTH - 1)) state_d = PARITY;
                end
            end
            PARITY: begin
                if (load_abort) do_fail = 1'b1;
                else if (transfer) begin
                    if (ser_data == par) begin
                        do_accept = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        do_fail = 1'b1;
                    end
                end
            end
            default: state_d = LOCKOUT;
        endcase
        if (do_fail) state_d = to_lock ? LOCKOUT : IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count      <= '0;
            fail_cnt   <= '0;
            key_out    <= '0;
            key_valid  <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
            locked_out <= 1'b0;
        end else begin
            if (do_start) begin
                count     <= '0;
                key_out   <= '0;
                key_valid <= 1'b0;
                err       <= 1'b0;
                busy      <= 1'b1;
            end
            if (do_write) count <= count + CNT_W'(1);
            if (do_accept) begin
                key_out   <= shreg;
                key_valid <= 1'b1;
                fail_cnt  <= '0;
                busy      <= 1'b0;
            end
            if (do_fail) begin
                err      <= 1'b1;
                busy     <= 1'b0;
                fail_cnt <= fail_next;
                if (to_lock) locked_out <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_locked_key_loader.sv
// Directed bench for locked_key_loader: transaction-level model plus literal spot checks.
module tb_locked_key_loader;
    import locked_key_pkg::*;

    localparam int KW = 4;
    localparam int MF = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_start = 1'b0, load_abort = 1'b0;
    logic          ser_valid = 1'b0, ser_data = 1'b0;
    logic          ser_ready, key_valid, busy, err, locked_out;
    logic [KW-1:0] key_out;

    int checks = 0;
    int errors = 0;

    locked_key_loader #(.KEY_WIDTH(KW), .MAX_FAILS(MF)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .load_abort (load_abort),
        .ser_valid  (ser_valid),
        .ser_data   (ser_data),
        .ser_ready  (ser_ready),
        .key_out    (key_out),
        .key_valid  (key_valid),
        .busy       (busy),
        .err        (err),
        .locked_out (locked_out)
    );

    always #5 clk = ~clk;

    // Model: a load is a collection of KW key bits plus parity; judged once the frame is complete.
    logic          m_loading, m_locked, m_key_valid, m_busy, m_err;
    logic [KW-1:0] m_key_out;
    int            m_fails;
    logic          bits[$];

    task automatic model_fail();
        m_err     = 1'b1;
        m_busy    = 1'b0;
        m_loading = 1'b0;
        m_fails++;
        if (m_fails == MF) m_locked = 1'b1;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_loading = 0; m_locked = 0; m_key_valid = 0; m_busy = 0; m_err = 0;
            m_key_out = '0; m_fails = 0;
            bits.delete();
        end else if (m_locked) begin
        end else if (!m_loading) begin
            if (load_start) begin
                m_loading = 1; m_key_out = '0; m_key_valid = 0; m_err = 0; m_busy = 1;
                bits.delete();
            end
        end else if (load_abort) begin
            model_fail();
        end else if (ser_valid) begin
            bits.push_back(ser_data);
            if (bits.size() == KW + 1) begin
                logic [KW-1:0] k;
                for (int i = 0; i < KW; i++) k[i] = bits[i];
                if (bits[KW] == even_parity(64'(k))) begin
                    m_key_out = k; m_key_valid = 1; m_fails = 0; m_busy = 0; m_loading = 0;
                end else begin
                    model_fail();
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("ser_ready",  32'(ser_ready),    32'(m_loading));
        chk("key_out",    32'(key_out),      32'(m_key_out));
        chk("key_valid",  32'(key_valid),    32'(m_key_valid));
        chk("busy",       32'(busy),         32'(m_busy));
        chk("err",        32'(err),          32'(m_err));
        chk("locked_out", 32'(locked_out),   32'(m_locked));
        chk("fail_cnt",   32'(dut.fail_cnt), 32'(m_fails));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
    endtask

    // frame[KW-1:0] is the key (LSB first), frame[KW] the parity bit.
    task automatic send(input logic [KW:0] frame, input bit stall);
        for (int i = 0; i <= KW; i++) begin
            if (stall) begin
                ser_valid = 1'b0;
                ser_data  = ~frame[i];
                step();
            end
            ser_valid = 1'b1;
            ser_data  = frame[i];
            step();
        end
        ser_valid = 1'b0;
        ser_data  = 1'b0;
    endtask

    initial begin
        #12;
        chk("reset_key_out", 32'(key_out), 32'h0);
        chk("reset_busy",    32'(busy),    32'h0);
        chk("reset_ready",   32'(ser_ready), 32'h0);
        rst = 1'b0;
        step();

        // Good load 0110 with parity 0
        start();
        send({1'b0, 4'b0110}, 1'b0);
        chk("good_key_out",   32'(key_out),   32'h6);
        chk("good_key_valid", 32'(key_valid), 32'h1);
        chk("good_busy",      32'(busy),      32'h0);
        step();

        // Same key with stalls; invalid cycles carry inverted data
        start();
        send({1'b0, 4'b0110}, 1'b1);
        chk("stall_key_out",   32'(key_out),   32'h6);
        chk("stall_key_valid", 32'(key_valid), 32'h1);

        // Bad parity, then good reload
        start();
        send({1'b0, 4'b1011}, 1'b0);
        chk("bad_err",       32'(err),          32'h1);
        chk("bad_key_valid", 32'(key_valid),    32'h0);
        chk("bad_key_out",   32'(key_out),      32'h0);
        chk("bad_fail_cnt",  32'(dut.fail_cnt), 32'h1);
        start();
        send({1'b1, 4'b1011}, 1'b0);
        chk("reload_key_out",  32'(key_out),      32'hB);
        chk("reload_err",      32'(err),          32'h0);
        chk("reload_fail_cnt", 32'(dut.fail_cnt), 32'h0);

        // Abort coincident with 2nd bit transfer
        start();
        ser_valid = 1'b1; ser_data = 1'b1; step();
        load_abort = 1'b1; ser_data = 1'b0; step();
        load_abort = 1'b0; ser_valid = 1'b0;
        chk("abort_err",      32'(err),          32'h1);
        chk("abort_busy",     32'(busy),         32'h0);
        chk("abort_key_out",  32'(key_out),      32'h0);
        chk("abort_fail_cnt", 32'(dut.fail_cnt), 32'h1);
        chk("abort_ready",    32'(ser_ready),    32'h0);

        // load_start during SHIFT is ignored; load of 1001 (parity 0) completes
        start();
        ser_valid = 1'b1; ser_data = 1'b1; step();
        load_start = 1'b1; ser_data = 1'b0; step();
        load_start = 1'b0;
        ser_data = 1'b0; step();
        ser_data = 1'b1; step();
        ser_data = 1'b0; step();
        ser_valid = 1'b0;
        chk("midstart_key_out", 32'(key_out),   32'h9);
        chk("midstart_valid",   32'(key_valid), 32'h1);

        // Three bad loads lock the loader
        for (int n = 0; n < MF; n++) begin
            start();
            send({1'b1, 4'b0011}, 1'b0);
        end
        chk("lock_locked", 32'(locked_out), 32'h1);
        chk("lock_key",    32'(key_out),    32'h0);
        start();
        chk("lock_ready",  32'(ser_ready),  32'h0);
        chk("lock_busy",   32'(busy),       32'h0);
        send({1'b0, 4'b0110}, 1'b0);
        chk("lock_hold",   32'(locked_out), 32'h1);

        // Reset clears lockout; then async reset mid-load after 2 bits
        rst = 1'b1; #1;
        chk("rst_unlock", 32'(locked_out), 32'h0);
        @(negedge clk); rst = 1'b0;
        step();
        start();
        ser_valid = 1'b1; ser_data = 1'b1; step();
        ser_data = 1'b1; step();
        chk("midload_busy", 32'(busy), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("async_busy",  32'(busy),      32'h0);
        chk("async_ready", 32'(ser_ready), 32'h0);
        chk("async_err",   32'(err),       32'h0);
        ser_valid = 1'b0;
        @(negedge clk); rst = 1'b0;
        step();
        start();
        send({1'b1, 4'b0111}, 1'b0);
        chk("fresh_key_out", 32'(key_out),   32'h7);
        chk("fresh_valid",   32'(key_valid), 32'h1);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/locked_key_loader.md
Name: locked_key_loader

Overview:
- Delivers the unlocking key to a logic-locked netlist's key inputs (keyIn0_0..keyIn0_N).
- Receives the key bit-serially over a valid/ready stream, checks an even-parity bit, then presents it in parallel.
- Holds key_out at all-zero whenever no validated key is held, so the locked core runs with a wrong key until loading succeeds.
- After MAX_FAILS consecutive failed loads, latches a lockout that only reset clears.

Parameters:
KEY_WIDTH, 4, number of key bits; bit i drives keyIn0_i.
MAX_FAILS, 3, consecutive parity failures before permanent lockout (>=1).

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  asynchronous, active-high reset.
load_start  input  1  1-cycle pulse: begin a new key load.
load_abort  input  1  abandon the load in progress.
ser_valid  input  1  ser_data holds a bit.
ser_data  input  1  serial key bit, LSB (keyIn0_0) first, then parity.
ser_ready  output  1  loader accepts a bit this cycle.
key_out  output  KEY_WIDTH  parallel key to the locked netlist.
key_valid  output  1  key_out holds a parity-checked key.
busy  output  1  load in progress.
err  output  1  last load failed (parity or abort); sticky until next load_start.
locked_out  output  1  lockout reached.

Behaviour:
- Reset (async, rst=1): all outputs 0; state IDLE; shift register 0; bit counter 0; fail counter 0.
- States: IDLE, SHIFT, PARITY, LOCKOUT. All outputs are registered except ser_ready, which is 1 exactly in SHIFT and PARITY.
- A transfer is ser_valid && ser_ready on a rising edge.
- IDLE:
  - load_start -> SHIFT next cycle.
  - Same edge: key_out<=0, key_valid<=0, err<=0, shift reg<=0, count<=0, busy<=1.
- SHIFT:
  - Each transfer writes shreg[count]<=ser_data and increments count.
  - The transfer at count==KEY_WIDTH-1 goes to PARITY.
  - ser_valid low stalls indefinitely; there is no timeout.
- PARITY: one transfer, with p = XOR of all shreg bits.
  - ser_data==p: key_out<=shreg, key_valid<=1, fail_cnt<=0, busy<=0, -> IDLE. key_valid is first high the cycle after the parity transfer.
  - Mismatch: err<=1, busy<=0, fail_cnt++. If the new count equals MAX_FAILS -> LOCKOUT, else -> IDLE.
  - key_out stays 0 on mismatch.
- load_abort in SHIFT or PARITY:
  - -> IDLE, err<=1, busy<=0. Counts as one failure, including the lockout check.
  - Abort has priority over a simultaneous transfer.
- load_abort in IDLE or LOCKOUT: ignored.
- load_start while busy: ignored. load_start and load_abort in the same IDLE cycle: start wins.
- LOCKOUT:
  - locked_out=1, key_out=0, key_valid=0, ser_ready=0.
  - All inputs ignored. Exit only via rst.
- Minimum load time: 1 cycle plus KEY_WIDTH+1 transfers, with one transfer per cycle when ser_valid is held high.
- fail_cnt width: clog2(MAX_FAILS+1). It saturates because LOCKOUT is entered at MAX_FAILS.
- rst asserted mid-load: immediate return to reset values; partial key discarded.

Decomposition:
- Shared package locked_key_pkg holds:
  - state enum (IDLE, SHIFT, PARITY, LOCKOUT);
  - default KEY_WIDTH and MAX_FAILS constants;
  - a function computing even parity over a key vector, for reuse by the bench model.
- One natural sub-module, key_shift_reg. It provides the indexed write, the clear, and the parallel read of KEY_WIDTH bits, reset asynchronously by rst.
- FSM, counters and output registers stay in the top module.

Test Plan:
- Good load: key 4'b0110 sent as 0,1,1,0 then parity 0, ser_valid held high -> key_valid=1 and key_out=4'b0110 the cycle after the 5th transfer; busy low the same cycle.
- Stalls: same key with ser_valid toggling every other cycle -> identical result; no bit accepted while ser_valid=0.
- Bad parity: key 4'b1011 sent with parity 0 -> err=1, key_valid=0, key_out=0, fail_cnt=1. A following good load of 4'b1011 with parity 1 -> key_valid=1, err=0, fail_cnt=0.
- Lockout: three consecutive bad-parity loads (MAX_FAILS=3) -> locked_out=1 after the 3rd. A further load_start leaves ser_ready=0; only rst clears it.
- Abort/priority: load_abort in the same cycle as the 2nd bit transfer -> IDLE, err=1, key_out=0, fail_cnt+1. load_start during SHIFT -> ignored, load continues.
- Reset mid-load: rst asserted asynchronously after 2 bits -> all outputs 0 immediately (before the next clock edge). A fresh load then works normally.
